// File: rtl/piece_move_ctrl.sv
// piece_move_ctrl: move/lock/spawn sequencer for the falling piece.
// Presents a candidate pose to the external 4-cell address generator,
// reads the four cells back from board RAM to test for collisions,
// commits legal moves, and locks/spawns on a blocked down move.
module piece_move_ctrl #(
  parameter int MAP_WIDTH   = 14,
  parameter int RAM_LATENCY = 2,
  parameter int SPAWN_X     = 5,
  parameter int SPAWN_Y     = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic [2:0] next_color_in,
  input  logic       cmd_valid_in,
  input  logic [1:0] cmd_in,
  output logic       cmd_ready_out,
  output logic [2:0] cand_color_out,
  output logic [1:0] cand_state_out,
  output logic [3:0] cand_x_out,
  output logic [4:0] cand_y_out,
  input  logic [8:0] addr1_in,
  input  logic [8:0] addr2_in,
  input  logic [8:0] addr3_in,
  input  logic [8:0] addr4_in,
  output logic [8:0] rd_addr_out,
  input  logic [2:0] rd_data_in,
  output logic       wr_en_out,
  output logic [8:0] wr_addr_out,
  output logic [2:0] wr_data_out,
  output logic [2:0] piece_color_out,
  output logic [1:0] piece_state_out,
  output logic [3:0] piece_x_out,
  output logic [4:0] piece_y_out,
  output logic       move_done_out,
  output logic       move_ok_out,
  output logic       lock_done_out,
  output logic       game_over_out
);

  typedef enum logic [3:0] {
    S_WAIT_START,
    S_IDLE,
    S_GEN,
    S_READ,
    S_DECIDE,
    S_LOCK_GEN,
    S_LOCK_WR,
    S_SPAWN_GEN,
    S_SPAWN_READ,
    S_SPAWN_DECIDE,
    S_OVER
  } state_t;

  typedef enum logic [1:0] {
    CMD_LEFT  = 2'd0,
    CMD_RIGHT = 2'd1,
    CMD_DOWN  = 2'd2,
    CMD_ROT   = 2'd3
  } cmd_t;

  // Counter covers the read window (4 issues + RAM latency) and the lock writes.
  localparam int CW = $clog2(RAM_LATENCY + 5);
  localparam logic [CW-1:0] N_CELLS   = CW'(4);
  localparam logic [CW-1:0] SAMPLE_LO = CW'(RAM_LATENCY);
  localparam logic [CW-1:0] LAST_READ = CW'(RAM_LATENCY + 3);
  // Spawn frame origin must lie inside the board stride.
  localparam logic [3:0] SPAWN_X4 = 4'((SPAWN_X < MAP_WIDTH) ? SPAWN_X : 1);
  localparam logic [4:0] SPAWN_Y5 = 5'(SPAWN_Y);

  state_t        state, next_state;
  cmd_t          cmd_q;
  logic [CW-1:0] cnt;
  logic          collision;
  logic          game_over;
  logic          pre_reject;
  logic [8:0]    sel_addr;
  logic [2:0]    cand_color, piece_color;
  logic [1:0]    cand_state, piece_state;
  logic [3:0]    cand_x, piece_x;
  logic [4:0]    cand_y, piece_y;

  assign cand_color_out  = cand_color;
  assign cand_state_out  = cand_state;
  assign cand_x_out      = cand_x;
  assign cand_y_out      = cand_y;
  assign piece_color_out = piece_color;
  assign piece_state_out = piece_state;
  assign piece_x_out     = piece_x;
  assign piece_y_out     = piece_y;
  assign game_over_out   = game_over;

  // Moves that would wrap x or y are refused without touching the RAM.
  always_comb begin
    pre_reject = 1'b0;
    case (cmd_t'(cmd_in))
      CMD_LEFT:  pre_reject = (piece_x == 4'd0);
      CMD_RIGHT: pre_reject = (piece_x == 4'hF);
      CMD_DOWN:  pre_reject = (piece_y == 5'h1F);
      default:   pre_reject = 1'b0;
    endcase
  end

  // Select which generator address is issued / written this cycle.
  always_comb begin
    sel_addr = addr1_in;
    case (cnt[1:0])
      2'd0:    sel_addr = addr1_in;
      2'd1:    sel_addr = addr2_in;
      2'd2:    sel_addr = addr3_in;
      default: sel_addr = addr4_in;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_WAIT_START;
    else           state <= next_state;
  end

  // Next-state and Moore-style outputs; all strobes derive from state so reset clears them at once.
  always_comb begin
    next_state    = state;
    cmd_ready_out = 1'b0;
    rd_addr_out   = '0;
    wr_en_out     = 1'b0;
    wr_addr_out   = '0;
    wr_data_out   = '0;
    move_done_out = 1'b0;
    move_ok_out   = 1'b0;
    lock_done_out = 1'b0;
    case (state)
      S_WAIT_START: if (start_in) next_state = S_SPAWN_GEN;
      S_IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in) begin
          // A refused left/right reuses DECIDE (collision preset) to report in cycle 1.
          if (pre_reject)
            next_state = (cmd_t'(cmd_in) == CMD_DOWN) ? S_LOCK_GEN : S_DECIDE;
          else
            next_state = S_GEN;
        end
      end
      S_GEN:       next_state = S_READ;
      S_SPAWN_GEN: next_state = S_SPAWN_READ;
      S_READ, S_SPAWN_READ: begin
        if (cnt < N_CELLS) rd_addr_out = sel_addr;
        if (cnt == LAST_READ)
          next_state = (state == S_READ) ? S_DECIDE : S_SPAWN_DECIDE;
      end
      S_DECIDE: begin
        move_done_out = 1'b1;
        move_ok_out   = !collision;
        next_state    = (collision && cmd_q == CMD_DOWN) ? S_LOCK_GEN : S_IDLE;
      end
      S_LOCK_GEN: next_state = S_LOCK_WR;
      S_LOCK_WR: begin
        if (cnt < N_CELLS) begin
          wr_en_out   = 1'b1;
          wr_addr_out = sel_addr;
          wr_data_out = piece_color;
        end else begin
          lock_done_out = 1'b1;
          next_state    = S_SPAWN_GEN;
        end
      end
      S_SPAWN_DECIDE: next_state = collision ? S_OVER : S_IDLE;
      S_OVER:         next_state = S_OVER;
      default:        next_state = S_WAIT_START;
    endcase
  end

  // Candidate/piece pose, collision flag and cycle counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cmd_q       <= CMD_LEFT;
      cnt         <= '0;
      collision   <= 1'b0;
      game_over   <= 1'b0;
      cand_color  <= '0;
      cand_state  <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      piece_color <= '0;
      piece_state <= '0;
      piece_x     <= '0;
      piece_y     <= '0;
    end else begin
      case (state)
        S_WAIT_START: begin
          if (start_in) begin
            cand_color <= next_color_in;
            cand_state <= '0;
            cand_x     <= SPAWN_X4;
            cand_y     <= SPAWN_Y5;
            collision  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (cmd_valid_in) begin
            cmd_q      <= cmd_t'(cmd_in);
            collision  <= pre_reject;
            cand_color <= piece_color;
            cand_state <= piece_state;
            cand_x     <= piece_x;
            cand_y     <= piece_y;
            if (!pre_reject) begin
              case (cmd_t'(cmd_in))
                CMD_LEFT:  cand_x     <= piece_x - 4'd1;
                CMD_RIGHT: cand_x     <= piece_x + 4'd1;
                CMD_DOWN:  cand_y     <= piece_y + 5'd1;
                default:   cand_state <= piece_state + 2'd1;
              endcase
            end
          end
        end
        S_GEN, S_SPAWN_GEN, S_LOCK_GEN: cnt <= '0;
        S_READ, S_SPAWN_READ: begin
          cnt <= cnt + 1'b1;
          if (cnt >= SAMPLE_LO && cnt <= LAST_READ && rd_data_in != 3'd0)
            collision <= 1'b1;
        end
        S_DECIDE: begin
          if (!collision) begin
            piece_color <= cand_color;
            piece_state <= cand_state;
            piece_x     <= cand_x;
            piece_y     <= cand_y;
          end else if (cmd_q == CMD_DOWN) begin
            cand_color <= piece_color;
            cand_state <= piece_state;
            cand_x     <= piece_x;
            cand_y     <= piece_y;
          end
        end
        S_LOCK_WR: begin
          cnt <= cnt + 1'b1;
          if (cnt == N_CELLS) begin
            cand_color <= next_color_in;
            cand_state <= '0;
            cand_x     <= SPAWN_X4;
            cand_y     <= SPAWN_Y5;
            collision  <= 1'b0;
          end
        end
        S_SPAWN_DECIDE: begin
          if (!collision) begin
            piece_color <= cand_color;
            piece_state <= cand_state;
            piece_x     <= cand_x;
            piece_y     <= cand_y;
          end else begin
            game_over <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl with a registered 4-cell address
// generator and a 2-cycle-latency board RAM around the DUT.
module tb_piece_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, cmd_valid;
  logic [2:0] next_color;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [2:0] cand_color;
  logic [1:0] cand_state;
  logic [3:0] cand_x;
  logic [4:0] cand_y;
  logic [8:0] a1, a2, a3, a4;
  logic [8:0] rd_addr;
  logic [2:0] rd_data;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [2:0] wr_data;
  logic [2:0] piece_color;
  logic [1:0] piece_state;
  logic [3:0] piece_x;
  logic [4:0] piece_y;
  logic       move_done, move_ok, lock_done, game_over;

  logic       clr_req = 1'b0;
  logic       tb_we = 1'b0;
  logic [8:0] tb_wa = '0;
  logic [2:0] tb_wd = '0;
  logic [2:0] mem [0:511];
  logic [2:0] p1, p2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piece_move_ctrl #(.MAP_WIDTH(14), .RAM_LATENCY(2), .SPAWN_X(5), .SPAWN_Y(0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .next_color_in(next_color),
    .cmd_valid_in(cmd_valid), .cmd_in(cmd), .cmd_ready_out(cmd_ready),
    .cand_color_out(cand_color), .cand_state_out(cand_state),
    .cand_x_out(cand_x), .cand_y_out(cand_y),
    .addr1_in(a1), .addr2_in(a2), .addr3_in(a3), .addr4_in(a4),
    .rd_addr_out(rd_addr), .rd_data_in(rd_data),
    .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .piece_color_out(piece_color), .piece_state_out(piece_state),
    .piece_x_out(piece_x), .piece_y_out(piece_y),
    .move_done_out(move_done), .move_ok_out(move_ok),
    .lock_done_out(lock_done), .game_over_out(game_over)
  );

  // Generator: color 1 is the I piece (row 1 / column 2 of the frame), others a 2x2 block.
  function automatic logic [8:0] cell_addr(input logic [2:0] c, input logic [1:0] s,
                                           input logic [3:0] x, input logic [4:0] y, input int i);
    int dx, dy;
    if (c == 3'd1) begin
      if (s[0] == 1'b0) begin dx = i; dy = 1; end
      else              begin dx = 2; dy = i; end
    end else begin
      dx = 1 + (i % 2);
      dy = i / 2;
    end
    return 9'((int'(y) + dy) * 14 + int'(x) + dx);
  endfunction

  always @(posedge clk) begin
    a1 <= cell_addr(cand_color, cand_state, cand_x, cand_y, 0);
    a2 <= cell_addr(cand_color, cand_state, cand_x, cand_y, 1);
    a3 <= cell_addr(cand_color, cand_state, cand_x, cand_y, 2);
    a4 <= cell_addr(cand_color, cand_state, cand_x, cand_y, 3);
  end

  // Board RAM: two-stage read pipeline, walls at columns 0 and 13.
  assign rd_data = p2;
  always @(posedge clk) begin
    p1 <= mem[rd_addr];
    p2 <= p1;
    if (clr_req) begin
      for (int i = 0; i < 512; i++)
        mem[i] <= ((i % 14) == 0 || (i % 14) == 13) ? 3'd7 : 3'd0;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; next_color = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_board;
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
  endtask

  task automatic poke(input logic [8:0] addr, input logic [2:0] data);
    @(negedge clk); tb_we = 1'b1; tb_wa = addr; tb_wd = data;
    @(negedge clk); tb_we = 1'b0;
  endtask

  // Pulses start and follows the spawn until the piece is ready or the game ends.
  task automatic start_piece(input logic [2:0] c, output int ready_at, output int over_at,
                             output int dones);
    ready_at = -1; over_at = -1; dones = 0;
    @(negedge clk); start = 1'b1; next_color = c;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (move_done) dones++;
      if (cmd_ready) begin ready_at = n; break; end
      if (game_over) begin over_at = n; break; end
      @(negedge clk);
    end
  endtask

  // Issues one command and returns when move_done is seen (n = cycles after accept).
  task automatic issue_cmd(input logic [1:0] c, output int done_at, output logic ok,
                           output logic [8:0] ra [4], output int nreads);
    done_at = -1; ok = 1'b0; nreads = 0;
    for (int k = 0; k < 4; k++) ra[k] = '0;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (cmd_ready) begin
      cmd_valid = 1'b1; cmd = c;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int n = 1; n <= 30; n++) begin
        if (rd_addr != 9'd0) begin
          if (nreads < 4) ra[2'(nreads)] = rd_addr;
          nreads++;
        end
        if (move_done) begin done_at = n; ok = move_ok; break; end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; next_color = 3'd0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", cmd_ready); end
    checks++;
    if ({move_done, move_ok, lock_done, game_over, wr_en} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000", {move_done, move_ok, lock_done, game_over, wr_en});
    end
    checks++;
    if ({piece_color, piece_state, piece_x, piece_y} !== 14'd0) begin
      errors++; $display("FAIL reset_piece: got %h expected 0", {piece_color, piece_state, piece_x, piece_y});
    end
    checks++;
    if ({cand_color, cand_state, cand_x, cand_y, rd_addr, wr_addr} !== 32'd0) begin
      errors++; $display("FAIL reset_cand_addr: got %h expected 0", {cand_color, cand_state, cand_x, cand_y, rd_addr, wr_addr});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wait_start_ready: got %0b expected 0", cmd_ready); end
  endtask

  task automatic test_spawn;
    int ready_at, over_at, dones;
    clear_board();
    start_piece(3'd5, ready_at, over_at, dones);
    checks++;
    if (ready_at !== 9) begin errors++; $display("FAIL spawn_ready_cycle: got %0d expected 9", ready_at); end
    checks++;
    if ({piece_color, piece_state, piece_x, piece_y} !== {3'd5, 2'd0, 4'd5, 5'd0}) begin
      errors++; $display("FAIL spawn_pose: got %h expected %h", {piece_color, piece_state, piece_x, piece_y}, {3'd5, 2'd0, 4'd5, 5'd0});
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL spawn_no_done: got %0d expected 0", dones); end
  endtask

  task automatic test_move_left;
    int done_at, nreads;
    logic ok;
    logic [8:0] ra [4];
    issue_cmd(2'd0, done_at, ok, ra, nreads);
    checks++;
    if (done_at !== 8) begin errors++; $display("FAIL left_done_cycle: got %0d expected 8", done_at); end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL left_ok: got %0b expected 1", ok); end
    checks++;
    if (nreads !== 4) begin errors++; $display("FAIL left_nreads: got %0d expected 4", nreads); end
    checks++;
    if ({ra[0], ra[1], ra[2], ra[3]} !== {9'd5, 9'd6, 9'd19, 9'd20}) begin
      errors++; $display("FAIL left_rd_addrs: got %0d %0d %0d %0d expected 5 6 19 20", ra[0], ra[1], ra[2], ra[3]);
    end
    @(negedge clk);
    checks++;
    if (piece_x !== 4'd4) begin errors++; $display("FAIL left_piece_x: got %0d expected 4", piece_x); end
  endtask

  task automatic test_wall_collision;
    int ready_at, over_at, dones, done_at, nreads;
    logic ok, all_ok;
    logic [8:0] ra [4];
    do_reset();
    clear_board();
    start_piece(3'd1, ready_at, over_at, dones);
    all_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_cmd(2'd0, done_at, ok, ra, nreads);
      all_ok = all_ok & ok;
    end
    @(negedge clk);
    checks++;
    if ({all_ok, piece_x} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL cyan_walk_left: got ok=%0b x=%0d expected ok=1 x=1", all_ok, piece_x);
    end
    issue_cmd(2'd0, done_at, ok, ra, nreads);
    checks++;
    if ({done_at, ok} !== {32'd8, 1'b0}) begin
      errors++; $display("FAIL wall_reject: got done=%0d ok=%0b expected done=8 ok=0", done_at, ok);
    end
    checks++;
    if (ra[0] !== 9'd14) begin errors++; $display("FAIL wall_rd_addr: got %0d expected 14", ra[0]); end
    @(negedge clk);
    checks++;
    if (piece_x !== 4'd1) begin errors++; $display("FAIL wall_piece_x: got %0d expected 1", piece_x); end
  endtask

  task automatic test_prereject_left;
    int done_at, nreads;
    logic ok;
    logic [8:0] ra [4];
    issue_cmd(2'd3, done_at, ok, ra, nreads);
    issue_cmd(2'd0, done_at, ok, ra, nreads);
    @(negedge clk);
    checks++;
    if ({piece_state, piece_x} !== {2'd1, 4'd0}) begin
      errors++; $display("FAIL vert_to_x0: got state=%0d x=%0d expected state=1 x=0", piece_state, piece_x);
    end
    issue_cmd(2'd0, done_at, ok, ra, nreads);
    checks++;
    if ({done_at, ok, nreads} !== {32'd1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL prereject_left: got done=%0d ok=%0b reads=%0d expected done=1 ok=0 reads=0", done_at, ok, nreads);
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, piece_x} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL prereject_after: got ready=%0b x=%0d expected ready=1 x=0", cmd_ready, piece_x);
    end
  endtask

  task automatic test_rotate_wrap;
    int done_at, nreads;
    logic ok;
    logic [8:0] ra [4];
    issue_cmd(2'd1, done_at, ok, ra, nreads);
    issue_cmd(2'd3, done_at, ok, ra, nreads);
    issue_cmd(2'd3, done_at, ok, ra, nreads);
    @(negedge clk);
    checks++;
    if ({piece_state, piece_x} !== {2'd3, 4'd1}) begin
      errors++; $display("FAIL rotate_to_3: got state=%0d x=%0d expected state=3 x=1", piece_state, piece_x);
    end
    issue_cmd(2'd3, done_at, ok, ra, nreads);
    checks++;
    if ({ok, cand_state} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL rotate_wrap_ok: got ok=%0b cand=%0d expected ok=1 cand=0", ok, cand_state);
    end
    @(negedge clk);
    checks++;
    if (piece_state !== 2'd0) begin errors++; $display("FAIL rotate_wrap_state: got %0d expected 0", piece_state); end
  endtask

  task automatic test_down_lock;
    int done_at, nreads, nw, lock_at, ready_at, first_wr, extra;
    logic ok;
    logic [8:0] ra [4];
    logic [8:0] wa [4];
    logic [2:0] wd [4];
    issue_cmd(2'd2, done_at, ok, ra, nreads);
    @(negedge clk);
    checks++;
    if ({ok, piece_y} !== {1'b1, 5'd1}) begin
      errors++; $display("FAIL down_clear: got ok=%0b y=%0d expected ok=1 y=1", ok, piece_y);
    end
    poke(9'd44, 3'd3);
    next_color = 3'd4;
    issue_cmd(2'd2, done_at, ok, ra, nreads);
    checks++;
    if ({done_at, ok} !== {32'd8, 1'b0}) begin
      errors++; $display("FAIL down_blocked: got done=%0d ok=%0b expected done=8 ok=0", done_at, ok);
    end
    nw = 0; lock_at = -1; ready_at = -1; first_wr = -1; extra = 0;
    for (int k = 0; k < 4; k++) begin wa[k] = '0; wd[k] = '0; end
    for (int n = 9; n <= 40; n++) begin
      @(negedge clk);
      if (wr_en) begin
        if (first_wr < 0) first_wr = n;
        if (nw < 4) begin wa[2'(nw)] = wr_addr; wd[2'(nw)] = wr_data; end
        nw++;
      end
      if (lock_done) lock_at = n;
      if (move_done) extra++;
      if (cmd_ready) begin ready_at = n; break; end
    end
    checks++;
    if ({nw, first_wr} !== {32'd4, 32'd10}) begin
      errors++; $display("FAIL lock_writes: got count=%0d first=%0d expected count=4 first=10", nw, first_wr);
    end
    checks++;
    if ({wa[0], wa[1], wa[2], wa[3]} !== {9'd29, 9'd30, 9'd31, 9'd32}) begin
      errors++; $display("FAIL lock_addrs: got %0d %0d %0d %0d expected 29 30 31 32", wa[0], wa[1], wa[2], wa[3]);
    end
    checks++;
    if ({wd[0], wd[1], wd[2], wd[3]} !== {3'd1, 3'd1, 3'd1, 3'd1}) begin
      errors++; $display("FAIL lock_data: got %0d %0d %0d %0d expected 1 1 1 1", wd[0], wd[1], wd[2], wd[3]);
    end
    checks++;
    if (lock_at !== 14) begin errors++; $display("FAIL lock_done_cycle: got %0d expected 14", lock_at); end
    checks++;
    if ({ready_at, extra} !== {32'd23, 32'd0}) begin
      errors++; $display("FAIL respawn_ready: got ready=%0d extra_done=%0d expected ready=23 extra_done=0", ready_at, extra);
    end
    checks++;
    if ({piece_color, piece_state, piece_x, piece_y} !== {3'd4, 2'd0, 4'd5, 5'd0}) begin
      errors++; $display("FAIL respawn_pose: got %h expected %h", {piece_color, piece_state, piece_x, piece_y}, {3'd4, 2'd0, 4'd5, 5'd0});
    end
  endtask

  task automatic test_game_over;
    int ready_at, over_at, dones, seen;
    do_reset();
    clear_board();
    poke(9'd20, 3'd2);
    start_piece(3'd5, ready_at, over_at, dones);
    checks++;
    if ({over_at, ready_at} !== {32'd9, -32'sd1}) begin
      errors++; $display("FAIL game_over_cycle: got over=%0d ready=%0d expected over=9 ready=-1", over_at, ready_at);
    end
    seen = 0;
    cmd_valid = 1'b1; cmd = 2'd2; start = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (cmd_ready || move_done || wr_en || rd_addr != 9'd0) seen++;
    end
    cmd_valid = 1'b0; start = 1'b0;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL over_ignores_inputs: got %0d active cycles expected 0", seen); end
    checks++;
    if ({game_over, piece_color} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL over_sticky: got go=%0b color=%0d expected go=1 color=0", game_over, piece_color);
    end
  endtask

  task automatic test_reset_mid_read;
    int ready_at, over_at, dones;
    logic [8:0] issued;
    do_reset();
    clear_board();
    start_piece(3'd5, ready_at, over_at, dones);
    cmd_valid = 1'b1; cmd = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    issued = rd_addr;
    checks++;
    if (issued !== 9'd5) begin errors++; $display("FAIL mid_read_issue: got %0d expected 5", issued); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_addr, cmd_ready, move_done, game_over, piece_x, cand_x} !== 20'd0) begin
      errors++; $display("FAIL mid_read_reset: got %h expected 0", {rd_addr, cmd_ready, move_done, game_over, piece_x, cand_x});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_move_left();
    test_wall_collision();
    test_prereject_left();
    test_rotate_wrap();
    test_down_lock();
    test_game_over();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_move_ctrl.md
Name: piece_move_ctrl

Overview:
- Sequences the falling-piece datapath: accepts move commands, drives the shared 4-cell address generator with a candidate pose, and reads the board RAM to check that pose for collisions.
- Commits legal moves. On a failed down move it locks the piece into the board, spawns the next piece and detects game over.
- Sits between the input/gravity logic and the board RAM; the renderer and line-clear logic consume its outputs.

Parameters:
- MAP_WIDTH, 14, board row stride in cells (walls at columns 0 and 13 are stored as non-zero cells).
- RAM_LATENCY, 2, board RAM read latency in cycles (rd_addr to rd_data).
- SPAWN_X, 5, spawn x of a new piece's 4x4 frame.
- SPAWN_Y, 0, spawn y of a new piece's 4x4 frame.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- start_in  input  1  pulse; spawns the first piece.
- next_color_in  input  3  color of the next piece to spawn (1..7).
- cmd_valid_in  input  1  move command valid.
- cmd_in  input  2  0=left, 1=right, 2=down, 3=rotate CW.
- cmd_ready_out  output  1  high only in IDLE.
- cand_color_out  output  3  pose presented to the address generator.
- cand_state_out  output  2  pose presented to the address generator.
- cand_x_out  output  4  pose presented to the address generator.
- cand_y_out  output  5  pose presented to the address generator.
- addr1_in, addr2_in, addr3_in, addr4_in  input  9 each  generator outputs, registered, valid 1 cycle after the cand_* change.
- rd_addr_out  output  9  board RAM read address.
- rd_data_in  input  3  board cell; 0 = empty.
- wr_en_out  output  1  board RAM write strobe.
- wr_addr_out  output  9  board RAM write address.
- wr_data_out  output  3  board RAM write data.
- piece_color_out, piece_state_out, piece_x_out, piece_y_out  output  3/2/4/5  committed piece pose, for the renderer.
- move_done_out  output  1  1-cycle pulse when a command finishes.
- move_ok_out  output  1  valid with move_done_out; 1 = command applied.
- lock_done_out  output  1  1-cycle pulse after the 4 lock writes; triggers line clear.
- game_over_out  output  1  sticky until reset.

Behaviour:
- Reset values:
  - All outputs 0.
  - piece_* and cand_* = 0.
  - State WAIT_START.
- States: WAIT_START, IDLE, GEN, READ, DECIDE, LOCK_GEN, LOCK_WR, SPAWN_GEN, SPAWN_READ, SPAWN_DECIDE, OVER.
- WAIT_START: start_in -> SPAWN_GEN, with cand = (next_color_in, 0, SPAWN_X, SPAWN_Y).
- IDLE: cmd_ready_out = 1. When cmd_valid_in is high (accept = cycle 0), load the candidate from the piece pose and apply the command:
  - left: x-1.
  - right: x+1.
  - down: y+1.
  - rotate: state+1 mod 4 (3 wraps to 0).
- Pre-reject (cycle 1, no RAM reads):
  - left with x=0, right with x=15, or down with y=31 is rejected in cycle 1.
  - Left/right pre-reject: move_done_out=1 and move_ok_out=0 in cycle 1, then IDLE.
  - Down pre-reject: go to LOCK_GEN.
- GEN (cycle 1): wait for the registered addresses.
- READ (cycles 2-5): drive rd_addr_out = addr1..addr4, one per cycle. In cycles 2+RAM_LATENCY .. 5+RAM_LATENCY, OR (rd_data_in != 0) into a collision flag; the flag is cleared at accept.
- DECIDE (cycle 6+RAM_LATENCY):
  - move_done_out=1 and move_ok_out = !collision.
  - If no collision, piece_* <= cand_* in the same cycle.
  - If there is a collision on a down command, go to LOCK_GEN instead of IDLE; move_done_out still pulses with move_ok_out=0.
- LOCK_GEN: cand <= current piece pose; wait 1 cycle.
- LOCK_WR: 4 consecutive cycles with wr_en_out=1, wr_addr_out = addr1..addr4, wr_data_out = piece_color_out. Then lock_done_out pulses for 1 cycle and the block moves to SPAWN_GEN with cand = (next_color_in, 0, SPAWN_X, SPAWN_Y). next_color_in is sampled in that cycle.
- SPAWN_GEN/READ/DECIDE: same timing as GEN/READ/DECIDE.
  - No collision: piece_* <= cand, go to IDLE, no move_done_out.
  - Collision: game_over_out=1, go to OVER.
- OVER: cmd_ready_out=0; every input is ignored until reset.
- cmd_ready_out is 0 in every state other than IDLE. Commands presented while not ready are not accepted; the requester holds them.
- wr_en_out is never high in the same cycle as a read issue.
- x/y arithmetic:
  - x is 4-bit and y is 5-bit.
  - Pre-reject prevents wrap-around on x and y.
  - The generator's address arithmetic uses 9-bit results.
- Reset mid-operation: immediate return to WAIT_START; an in-flight lock write is abandoned (wr_en_out drops asynchronously).
- start_in is ignored outside WAIT_START.

Test Plan:
- Reset, start_in with next_color=5 on an empty board (walls only) -> after 6+2 cycles piece=(5,0,5,0), cmd_ready_out=1, no move_done_out.
- Piece at x=5, cmd left on an empty board -> move_done_out at cycle 8 after accept, move_ok_out=1, piece_x_out=4; exactly 4 rd_addr_out values, matching addr1..4.
- Cyan piece state 0 at x=1 (cells at columns 1-4), cmd left -> reads hit the wall at column 0, move_ok_out=0, piece_x_out stays 1.
- Rotate from state 3 -> candidate state 0; if clear, piece_state_out=0.
- Down blocked by a floor cell -> move_done_out with move_ok_out=0, then 4 writes of the piece color at the current-pose addresses, lock_done_out pulse, spawn of next_color_in.
- Spawn area pre-filled -> game_over_out=1; later commands are not accepted; rst_n_in low mid-READ -> all outputs return to 0 immediately.
